// File: rtl/alu_seq_pkg.sv
// Shared opcodes, operand source codes and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_NOT = 3;
    localparam int OP_ADD = 4;
    localparam int OP_SUB = 5;
    localparam int OP_SHL = 6;
    localparam int OP_SHR = 7;
    localparam int OP_MUL = 8;
    localparam int OP_DIV = 9;

    localparam int SRC_BIT  = 0;
    localparam int SRC_WORD = 1;
    localparam int SRC_RF   = 2;
    localparam int SRC_IMM  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle for WIDTH cycles.
// lo_next/hi_next expose the result of the step in progress so the last step can be registered directly.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next,
    output logic             last,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    assign last     = step && (cnt_q == CW'(WIDTH - 1));
    assign lo_next  = lo_step;
    assign hi_next  = hi_step;
    assign div_zero = div_q && (opnd_q == '0);

    // acc/mq hold {product high, multiplier} for MUL and {remainder, quotient} for DIV.
    // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        add     = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
        shifted = {acc_q, mq_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        ge      = (shifted >= {1'b0, opnd_q});
        if (div_q) begin
            hi_step = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_step = {mq_q[WIDTH-2:0], ge};
        end else begin
            hi_step = add[WIDTH:1];
            lo_step = {add[0], mq_q[WIDTH-1:1]};
        end
        if (load) begin
            acc_d  = '0;
            mq_d   = a;
            opnd_d = b;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (step) begin
            acc_d = hi_step;
            mq_d  = lo_step;
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            mq_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: dual operand source muxes, start/busy/done handshake, registered result and flags.
// Define ALU_SEQ_MULDIV_EN to build the iterative MUL/DIV engine; otherwise opcodes 08/09 are illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IWIDTH  = 8,
    parameter int SOURCES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IWIDTH-1:0]          op_code,
    input  logic [$clog2(SOURCES)-1:0] source1_choice,
    input  logic                       bit_mem_a,
    input  logic [WIDTH-1:0]           word_mem_a,
    input  logic [WIDTH-1:0]           rf_a,
    input  logic [WIDTH-1:0]           imm_a,
    input  logic [$clog2(SOURCES)-1:0] source2_choice,
    input  logic                       bit_mem_b,
    input  logic [WIDTH-1:0]           word_mem_b,
    input  logic [WIDTH-1:0]           rf_b,
    input  logic [WIDTH-1:0]           imm_b,
    input  logic                       alu_c_in,
    input  logic                       alu_b_in,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           alu_out,
    output logic [WIDTH-1:0]           alu_out_hi,
    output logic                       alu_c_out,
    output logic                       alu_b_out,
    output logic                       alu_z_out,
    output logic                       alu_err
);

    localparam int SW = $clog2(SOURCES);

    localparam logic [IWIDTH-1:0] L_AND = IWIDTH'(OP_AND);
    localparam logic [IWIDTH-1:0] L_OR  = IWIDTH'(OP_OR);
    localparam logic [IWIDTH-1:0] L_XOR = IWIDTH'(OP_XOR);
    localparam logic [IWIDTH-1:0] L_NOT = IWIDTH'(OP_NOT);
    localparam logic [IWIDTH-1:0] L_ADD = IWIDTH'(OP_ADD);
    localparam logic [IWIDTH-1:0] L_SUB = IWIDTH'(OP_SUB);
    localparam logic [IWIDTH-1:0] L_SHL = IWIDTH'(OP_SHL);
    localparam logic [IWIDTH-1:0] L_SHR = IWIDTH'(OP_SHR);
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [IWIDTH-1:0] L_MUL = IWIDTH'(OP_MUL);
    localparam logic [IWIDTH-1:0] L_DIV = IWIDTH'(OP_DIV);
`endif

    function automatic logic [WIDTH-1:0] pick_source(
        input logic [SW-1:0]    sel,
        input logic             bit_v,
        input logic [WIDTH-1:0] word_v,
        input logic [WIDTH-1:0] rf_v,
        input logic [WIDTH-1:0] imm_v
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (32'(sel))
            SRC_BIT:  r = {{(WIDTH-1){1'b0}}, bit_v};
            SRC_WORD: r = word_v;
            SRC_RF:   r = rf_v;
            SRC_IMM:  r = imm_v;
            default:  r = '0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             c_q, c_d;
    logic             b_q, b_d;
    logic             z_q, z_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_b;
    logic             res_err;
    logic             is_md;

    assign opa = pick_source(source1_choice, bit_mem_a, word_mem_a, rf_a, imm_a);
    assign opb = pick_source(source2_choice, bit_mem_b, word_mem_b, rf_b, imm_b);

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_load;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_last;
    logic             md_div_zero;

    assign md_load = start && (state_q != ST_RUN) && is_md;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .is_div   (op_code == L_DIV),
        .a        (opa),
        .b        (opb),
        .step     (state_q == ST_RUN),
        .lo_next  (md_lo),
        .hi_next  (md_hi),
        .last     (md_last),
        .div_zero (md_div_zero)
    );
`endif

    // Single-cycle result; sum/diff bit WIDTH is the carry / borrow.
    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, alu_c_in};
        diff    = {1'b0, opa} - {1'b0, opb} - {{WIDTH{1'b0}}, alu_b_in};
        res     = '0;
        res_c   = 1'b0;
        res_b   = 1'b0;
        res_err = 1'b0;
        is_md   = 1'b0;
        case (op_code)
            L_AND: res = opa & opb;
            L_OR:  res = opa | opb;
            L_XOR: res = opa ^ opb;
            L_NOT: res = ~opa;
            L_ADD: {res_c, res} = sum;
            L_SUB: {res_b, res} = diff;
            L_SHL: begin
                res   = {opa[WIDTH-2:0], 1'b0};
                res_c = opa[WIDTH-1];
            end
            L_SHR: begin
                res   = {1'b0, opa[WIDTH-1:1]};
                res_c = opa[0];
            end
`ifdef ALU_SEQ_MULDIV_EN
            L_MUL, L_DIV: is_md = 1'b1;
`endif
            default: res_err = 1'b1;
        endcase
    end

    // Outputs only change on the cycle that raises done; otherwise they hold.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        out_d   = out_q;
        hi_d    = hi_q;
        c_d     = c_q;
        b_d     = b_q;
        z_d     = z_q;
        err_d   = err_q;
        if (state_q == ST_RUN) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (md_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                out_d   = md_div_zero ? '1 : md_lo;
                hi_d    = md_hi;
                c_d     = 1'b0;
                b_d     = 1'b0;
                err_d   = md_div_zero;
            end
`endif
        end else if (start) begin
            if (is_md) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                out_d   = res;
                hi_d    = '0;
                c_d     = res_c;
                b_d     = res_b;
                err_d   = res_err;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
        if (done_d) begin
            z_d = (out_d == '0);
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            c_q     <= 1'b0;
            b_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            c_q     <= c_d;
            b_q     <= b_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alu_out    = out_q;
    assign alu_out_hi = hi_q;
    assign alu_c_out  = c_q;
    assign alu_b_out  = b_q;
    assign alu_z_out  = z_q;
    assign alu_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written multi-cycle sequences and random ops vs. a reference model.
// Expectations for opcodes 08/09 follow ALU_SEQ_MULDIV_EN when it is defined for the build.
module tb_alu_seq;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] op_code;
    logic [1:0] source1_choice, source2_choice;
    logic       bit_mem_a, bit_mem_b;
    logic [7:0] word_mem_a, rf_a, imm_a;
    logic [7:0] word_mem_b, rf_b, imm_b;
    logic       alu_c_in, alu_b_in;
    logic       busy, done;
    logic [7:0] alu_out, alu_out_hi;
    logic       alu_c_out, alu_b_out, alu_z_out, alu_err;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(W), .IWIDTH(8), .SOURCES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op_code        (op_code),
        .source1_choice (source1_choice),
        .bit_mem_a      (bit_mem_a),
        .word_mem_a     (word_mem_a),
        .rf_a           (rf_a),
        .imm_a          (imm_a),
        .source2_choice (source2_choice),
        .bit_mem_b      (bit_mem_b),
        .word_mem_b     (word_mem_b),
        .rf_b           (rf_b),
        .imm_b          (imm_b),
        .alu_c_in       (alu_c_in),
        .alu_b_in       (alu_b_in),
        .busy           (busy),
        .done           (done),
        .alu_out        (alu_out),
        .alu_out_hi     (alu_out_hi),
        .alu_c_out      (alu_c_out),
        .alu_b_out      (alu_b_out),
        .alu_z_out      (alu_z_out),
        .alu_err        (alu_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       bin;
        logic [7:0] eout;
        logic [7:0] ehi;
        logic       ec;
        logic       eb;
        logic       ez;
        logic       eerr;
    } vec_t;

    vec_t vecs[12];

    task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: the operation's rules in plain integer arithmetic.
    task automatic model(input int op, input int a, input int b, input int cin, input int bin,
                         output int out, output int hi, output int c, output int bo,
                         output int z, output int err, output int lat);
        int s;
        out = 0; hi = 0; c = 0; bo = 0; err = 0; lat = 1;
        case (op)
            0: out = a & b;
            1: out = a | b;
            2: out = a ^ b;
            3: out = 255 - a;
            4: begin s = a + b + cin; out = s % 256; c = (s > 255) ? 1 : 0; end
            5: begin s = a - b - bin; bo = (s < 0) ? 1 : 0; out = (s + 512) % 256; end
            6: begin out = (a * 2) % 256; c = a / 128; end
            7: begin out = a / 2; c = a % 2; end
`ifdef ALU_SEQ_MULDIV_EN
            8: begin out = (a * b) % 256; hi = (a * b) / 256; lat = W + 1; end
            9: begin
                lat = W + 1;
                if (b == 0) begin out = 255; hi = a; err = 1; end
                else begin out = a / b; hi = a % b; end
            end
`endif
            default: err = 1;
        endcase
        z = (out == 0) ? 1 : 0;
    endtask

    // Drives the selected source with the operand and scrambles the unselected ones, then waits for done.
    task automatic applyStimulus(input logic [7:0] op, input logic [1:0] s1, input logic [7:0] a,
                                 input logic [1:0] s2, input logic [7:0] b,
                                 input logic cin, input logic bin, output int lat);
        @(negedge clk);
        bit_mem_a  = 1'($urandom); word_mem_a = 8'($urandom); rf_a = 8'($urandom); imm_a = 8'($urandom);
        bit_mem_b  = 1'($urandom); word_mem_b = 8'($urandom); rf_b = 8'($urandom); imm_b = 8'($urandom);
        case (s1)
            2'd0: bit_mem_a = a[0];
            2'd1: word_mem_a = a;
            2'd2: rf_a = a;
            default: imm_a = a;
        endcase
        case (s2)
            2'd0: bit_mem_b = b[0];
            2'd1: word_mem_b = b;
            2'd2: rf_b = b;
            default: imm_b = b;
        endcase
        op_code = op; source1_choice = s1; source2_choice = s2;
        alu_c_in = cin; alu_b_in = bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string nm, input logic [7:0] eo, input logic [7:0] eh,
                               input logic ec, input logic eb, input logic ez, input logic ee,
                               input int elat, input int alat);
        checkVal({nm, ".lat"}, alat, elat);
        checkVal({nm, ".out"}, alu_out, eo);
        checkVal({nm, ".hi"}, alu_out_hi, eh);
        checkVal({nm, ".c"}, alu_c_out, ec);
        checkVal({nm, ".b"}, alu_b_out, eb);
        checkVal({nm, ".z"}, alu_z_out, ez);
        checkVal({nm, ".err"}, alu_err, ee);
    endtask

    task automatic runModelled(input string nm, input logic [7:0] op, input logic [1:0] s1, input logic [7:0] a,
                               input logic [1:0] s2, input logic [7:0] b, input logic cin, input logic bin);
        int lat, mo, mh, mc, mb, mz, me, ml, ea, eb;
        ea = (s1 == 2'd0) ? int'(a[0]) : int'(a);
        eb = (s2 == 2'd0) ? int'(b[0]) : int'(b);
        model(int'(op), ea, eb, int'(cin), int'(bin), mo, mh, mc, mb, mz, me, ml);
        applyStimulus(op, s1, a, s2, b, cin, bin, lat);
        checkOutput(nm, 8'(mo), 8'(mh), 1'(mc), 1'(mb), 1'(mz), 1'(me), ml, lat);
    endtask

    initial begin
        int lat, busyCnt, sawDone, mo, mh, mc, mb, mz, me, ml;
        logic [7:0] ra, rb, rop;
        logic [1:0] rs1, rs2;
        int r;

        vecs[0]  = '{8'h00, 2'd2, 2'd3, 8'h99, 8'hAA, 1'b0, 1'b0, 8'h88, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h04, 2'd1, 2'd2, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h05, 2'd3, 2'd1, 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h05, 2'd2, 2'd3, 8'h20, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'h01, 2'd0, 2'd3, 8'h01, 8'h40, 1'b0, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h02, 2'd2, 2'd2, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h03, 2'd3, 2'd1, 8'h5A, 8'h33, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h06, 2'd3, 2'd0, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h07, 2'd3, 2'd0, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h3C, 2'd2, 2'd2, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{8'h04, 2'd1, 2'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'h05, 2'd0, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; op_code = '0;
        source1_choice = '0; source2_choice = '0;
        bit_mem_a = 1'b0; word_mem_a = '0; rf_a = '0; imm_a = '0;
        bit_mem_b = 1'b0; word_mem_b = '0; rf_b = '0; imm_b = '0;
        alu_c_in = 1'b0; alu_b_in = 1'b0;
        #12;
        checkVal("reset.busy", busy, 0);
        checkVal("reset.done", done, 0);
        checkOutput("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].s1, vecs[i].a, vecs[i].s2, vecs[i].b,
                          vecs[i].cin, vecs[i].bin, lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].eout, vecs[i].ehi, vecs[i].ec,
                        vecs[i].eb, vecs[i].ez, vecs[i].eerr, 1, lat);
        end

        @(posedge clk);
        #1;
        checkVal("done.pulse", done, 0);
        checkVal("hold.out", alu_out, 8'h00);

        // MUL 0x0F x 0x11 with a stray start pulse while busy.
        @(negedge clk);
        op_code = 8'h08; source1_choice = 2'd2; rf_a = 8'h0F; source2_choice = 2'd3; imm_b = 8'h11;
        alu_c_in = 1'b0; alu_b_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1; busyCnt = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) busyCnt++;
            if (lat == 3) begin op_code = 8'h04; rf_a = 8'h01; imm_b = 8'h01; start = 1'b1; end
            if (lat == 4) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        model(8, 15, 17, 0, 0, mo, mh, mc, mb, mz, me, ml);
        checkVal("mul.busycycles", busyCnt, ml - 1);
        checkOutput("mul", 8'(mo), 8'(mh), 1'b0, 1'b0, 1'(mz), 1'(me), ml, lat);
`ifdef ALU_SEQ_MULDIV_EN
        checkVal("mul.product", {alu_out_hi, alu_out}, 16'h00FF);
`else
        checkVal("mul.illegal", {alu_err, alu_out}, 9'h100);
`endif

        runModelled("div", 8'h09, 2'd1, 8'h64, 2'd2, 8'h07, 1'b0, 1'b0);
        runModelled("div0", 8'h09, 2'd3, 8'h55, 2'd1, 8'h00, 1'b0, 1'b0);
`ifdef ALU_SEQ_MULDIV_EN
        checkVal("div0.pair", {alu_out_hi, alu_out}, 16'h55FF);
`endif

        // Asynchronous reset in the middle of a MUL.
        runModelled("pre", 8'h00, 2'd2, 8'h99, 2'd3, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        op_code = 8'h08; source1_choice = 2'd2; rf_a = 8'h0F; source2_choice = 2'd2; rf_b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model(8, 15, 17, 0, 0, mo, mh, mc, mb, mz, me, ml);
        checkVal("run.hold", alu_out, (ml > 1) ? 32'h88 : 32'h00);
        #2;
        rst = 1'b1;
        #1;
        checkVal("arst.busy", busy, 0);
        checkVal("arst.done", done, 0);
        checkOutput("arst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) sawDone = 1;
        end
        checkVal("arst.nodone", sawDone, 0);
        runModelled("post", 8'h04, 2'd3, 8'h12, 2'd1, 8'h34, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 12);
            rop = (r >= 10) ? 8'(r * 20) : 8'(r);
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            runModelled($sformatf("rnd%0d", i), rop, rs1, ra, rs2, rb, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational ALU of the CPU datapath.
- Keeps the same dual-operand source selection (bit memory, word memory, register file, immediate) and carry/borrow chaining.
- Adds a start/busy/done handshake, registered result and flags, and iterative multiply/divide.
- Sits between the operand muxes/decoder and the register-file write-back stage.

Parameters:
- WIDTH, 8, data width of operands and result; must be ≥ 2.
- IWIDTH, 8, opcode width.
- SOURCES, 4, number of selectable operand sources; select width is $clog2(SOURCES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op_code  input  IWIDTH  operation, latched on accepted start.
- source1_choice  input  $clog2(SOURCES)  operand A select.
- bit_mem_a  input  1  A source 0, zero-extended.
- word_mem_a  input  WIDTH  A source 1.
- rf_a  input  WIDTH  A source 2.
- imm_a  input  WIDTH  A source 3.
- source2_choice, bit_mem_b, word_mem_b, rf_b, imm_b: same as the A set, for operand B.
- alu_c_in  input  1  carry in, used by ADD.
- alu_b_in  input  1  borrow in, used by SUB.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- alu_out  output  WIDTH  result, low half.
- alu_out_hi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops.
- alu_c_out  output  1  carry / shifted-out bit.
- alu_b_out  output  1  borrow out.
- alu_z_out  output  1  alu_out == 0.
- alu_err  output  1  illegal opcode or divide by zero.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, iteration counter 0. Reset mid-operation aborts the operation with no done pulse.
- Source codes: 0 = bit, 1 = word, 2 = rf, 3 = imm; codes ≥ 4 select 0.
- Opcodes:
  - 00 AND, 01 OR, 02 XOR, 03 NOT A.
  - 04 ADD: A + B + c_in.
  - 05 SUB: A − B − b_in.
  - 06 SHL A by 1: c_out = A[MSB].
  - 07 SHR A by 1: c_out = A[0].
  - 08 MUL: unsigned, 2·WIDTH product.
  - 09 DIV: unsigned, quotient in alu_out, remainder in alu_out_hi.
  - Any other opcode → result 0, alu_err = 1.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start, single-cycle op → compute and register; DONE next cycle. Latency 1: done high the cycle after start.
  - IDLE/DONE + start, MUL/DIV → latch operands, RUN, counter = 0.
  - RUN → one shift-add (MUL) or restoring-subtract (DIV) step per cycle. After WIDTH steps → DONE. done high WIDTH+1 cycles after start.
  - DONE without start → IDLE.
- Back-to-back: start in the DONE cycle is accepted.
- busy = 1 only in RUN. start while busy is ignored; operands and sources are not re-sampled.
- Outputs hold their value from done until the next done or reset.
- Flags:
  - c_out valid for ADD/SHL/SHR, b_out valid for SUB; both 0 for all other ops.
  - z_out is evaluated on alu_out only.
  - alu_err is 0 unless set by the current operation.
- Divide by zero: alu_out = all ones, alu_out_hi = A, alu_err = 1. Still takes WIDTH+1 cycles.
- Arithmetic is modulo 2^WIDTH. ADD carry is bit WIDTH of the sum; SUB borrow is 1 when A < B + b_in.

Optional Feature:
- ALU_SEQ_MULDIV_EN defined: MUL/DIV implemented as above.
- Not defined: no iterative engine. Opcodes 08/09 are treated as illegal (1-cycle, result 0, alu_err = 1), and busy is never asserted.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_AND..OP_DIV;
  - source codes SRC_BIT, SRC_WORD, SRC_RF, SRC_IMM;
  - FSM state encoding.
- One sub-module, alu_seq_muldiv: the iterative shift-add/restoring-divide datapath with its step counter and last-step flag, instantiated only under ALU_SEQ_MULDIV_EN.

Test Plan:
- AND, src1 = rf 0x99, src2 = imm 0xAA, start → next cycle done = 1, alu_out = 0x88, z = 0, c = b = 0.
- ADD 0xF0 + 0x20, c_in = 1 → alu_out = 0x11, c_out = 1; SUB 0x10 − 0x20, b_in = 0 → 0xF0, b_out = 1; SUB 0x20 − 0x20 → 0x00, z = 1.
- MUL 0x0F × 0x11 → busy high 8 cycles, done on cycle 9, {hi,lo} = 0x00FF; start pulsed while busy is ignored.
- DIV 0x64 / 0x07 → alu_out = 0x0E, alu_out_hi = 0x02; DIV 0x55 / 0 → alu_out = 0xFF, hi = 0x55, alu_err = 1.
- Opcode 0x3C → done after 1 cycle, alu_out = 0, alu_err = 1; without ALU_SEQ_MULDIV_EN, op 08 behaves identically.
- rst asserted asynchronously on cycle 4 of MUL → all outputs 0 immediately, no done. A fresh ADD afterwards completes normally.
